// File: rtl/img_fb_pkg.sv
// rtl/img_fb_pkg.sv - shared types and width helper for the image frame buffer
//
// Purpose: holds the frame buffer FSM state encoding and the log2 helper used
// to derive address widths from the pixel/beat geometry.
// Ports: none (package).

package img_fb_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CLEAR,
    ST_SWAP_PEND
  } fb_state_e;

  // Smallest r with 2**r >= n; usable in constant (parameter) context.
  function automatic int fb_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/img_fb_mem.sv
// rtl/img_fb_mem.sv - simple dual-port wide-word RAM with registered read
//
// Purpose: backing store for both frame banks; one write port, one read port,
// no reset on the array or read register so it maps onto block RAM.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write word address
//   wdata  write word
//   re     read enable (loads rdata at the clock edge)
//   raddr  read word address
//   rdata  registered read word

module img_fb_mem #(
  parameter int WIDTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] ram [2**AW];

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/img_frame_buf.sv
// rtl/img_frame_buf.sv - double-buffered pixel frame buffer with swap and clear engine
//
// Purpose: decoder writes wide beats into the back bank, display reads single
// pixels from the front bank with 1-cycle registered, valid-qualified output.
// Swaps are requested and acknowledged; an optional clear engine zeroes a bank
// one beat per cycle (both banks after reset).
// Optional feature macro: IMG_FRAME_BUF_CLEAR_EN (clear engine, INIT/CLEAR states).
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data write beat into back bank; wr_ready high when not busy
//   rd_en/rd_addr         pixel read from front bank; rd_data/rd_valid 1 cycle later
//   swap_req/swap_ack     bank exchange request / one-cycle acknowledge
//   clear_req/busy        zero the back bank / clear engine active
//   front_bank            bank currently being read

module img_frame_buf
  import img_fb_pkg::*;
#(
  parameter int  PIX_W    = 8,
  parameter int  DEPTH    = 1024,
  parameter int  BEAT_PIX = 16,
  localparam int NBEAT    = DEPTH / BEAT_PIX,
  localparam int AW_R     = fb_log2(DEPTH),
  localparam int AW_W     = fb_log2(NBEAT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW_W-1:0]           wr_addr,
  input  logic [BEAT_PIX*PIX_W-1:0] wr_data,
  output logic                      wr_ready,
  input  logic                      rd_en,
  input  logic [AW_R-1:0]           rd_addr,
  output logic [PIX_W-1:0]          rd_data,
  output logic                      rd_valid,
  input  logic                      swap_req,
  output logic                      swap_ack,
  input  logic                      clear_req,
  output logic                      busy,
  output logic                      front_bank
);

  localparam int SELW = fb_log2(BEAT_PIX);
  localparam int WW   = BEAT_PIX * PIX_W;
  localparam int AWC  = AW_W + 1;
  localparam logic [AWC-1:0]  INIT_LAST = AWC'(2 * NBEAT - 1);
  localparam logic [AW_W-1:0] CLR_LAST  = AW_W'(NBEAT - 1);

`ifdef IMG_FRAME_BUF_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  fb_state_e       state, state_nxt;
  logic [AWC-1:0]  cnt;        // INIT walks {bank,beat}; CLEAR uses the beat bits only
  logic [AWC-1:0]  clr_addr;
  logic            pend;       // swap requested while the clear engine was busy
  logic            clr_we, clr_last, swap_go;
  logic            mem_we;
  logic [AWC-1:0]  mem_waddr;
  logic [WW-1:0]   mem_wdata;
  logic [WW-1:0]   rd_word;
  logic [SELW-1:0] rd_sel;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (CLEAR_EN) state <= ST_INIT;
      else          state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT, ST_CLEAR: begin
        if (clr_last) begin
          if (pend || swap_req) state_nxt = ST_SWAP_PEND;
          else                  state_nxt = ST_IDLE;
        end
      end
      ST_IDLE:      if (CLEAR_EN && clear_req) state_nxt = ST_CLEAR;
      ST_SWAP_PEND: state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_last = 1'b0;
    clr_addr = cnt;
    swap_go  = 1'b0;
    case (state)
      ST_INIT: begin
        busy     = 1'b1;
        clr_we   = 1'b1;
        clr_last = (cnt == INIT_LAST);
      end
      ST_CLEAR: begin
        busy     = 1'b1;
        clr_we   = 1'b1;
        clr_addr = {~front_bank, cnt[AW_W-1:0]};
        clr_last = (cnt[AW_W-1:0] == CLR_LAST);
      end
      // A clear requested in the same cycle wins; the swap is deferred behind it.
      ST_IDLE:      swap_go = swap_req && !(CLEAR_EN && clear_req);
      ST_SWAP_PEND: swap_go = 1'b1;
      default:      ;
    endcase
  end

  assign wr_ready = ~busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      pend       <= 1'b0;
      front_bank <= 1'b0;
      swap_ack   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_sel     <= '0;
    end else begin
      swap_ack <= swap_go;
      if (swap_go) front_bank <= ~front_bank;
      if (clr_we) cnt <= clr_last ? '0 : cnt + 1'b1;
      // Any number of swap requests during a clear collapse into one swap.
      if (busy)                  pend <= clr_last ? 1'b0 : (pend | swap_req);
      else if (state == ST_IDLE) pend <= CLEAR_EN && clear_req && swap_req;
      rd_valid <= rd_en;
      if (rd_en) rd_sel <= rd_addr[SELW-1:0];
    end
  end

  // Clear beats and decoder beats share the single RAM write port.
  assign mem_we    = clr_we | (wr_en & ~busy);
  assign mem_waddr = clr_we ? clr_addr : {~front_bank, wr_addr};
  assign mem_wdata = clr_we ? '0 : wr_data;

  img_fb_mem #(
    .WIDTH(WW),
    .AW   (AWC)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (rd_en),
    .raddr({front_bank, rd_addr[AW_R-1:SELW]}),
    .rdata(rd_word)
  );

  assign rd_data = rd_valid ? rd_word[rd_sel*PIX_W +: PIX_W] : '0;

endmodule

// File: tb/tb_img_frame_buf.sv
// tb/tb_img_frame_buf.sv - randomized self-checking bench for img_frame_buf against a bank-array model

module tb_img_frame_buf;

  localparam int NB  = 64;
  localparam int DEP = 1024;
  localparam int BP  = 16;

`ifdef IMG_FRAME_BUF_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic         clk, reset;
  logic         wr_en, wr_ready;
  logic [5:0]   wr_addr;
  logic [127:0] wr_data;
  logic         rd_en, rd_valid;
  logic [9:0]   rd_addr;
  logic [7:0]   rd_data;
  logic         swap_req, swap_ack, clear_req, busy, front_bank;

  img_frame_buf dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .clear_req (clear_req),
    .busy      (busy),
    .front_bank(front_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: two banks of pixels, which bank is front, and what the next cycle must show.
  logic [7:0] mem_m [2][DEP];
  bit         known [2][DEP];
  bit         front_m, exp_valid, exp_known, exp_ack;
  logic [7:0] exp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit rbit(input int one_in);
    return ($urandom() % one_in) == 0;
  endfunction

  task automatic drive(input bit we, input int wa, input logic [127:0] wd,
                       input bit re, input int ra, input bit sw, input bit cl);
    wr_en     = we;
    wr_addr   = 6'(wa);
    wr_data   = wd;
    rd_en     = re;
    rd_addr   = 10'(ra);
    swap_req  = sw;
    clear_req = cl;
  endtask

  task automatic check_out(input bit exp_busy);
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (!exp_valid)     check("rd_data_zero", 32'(rd_data), 32'(0));
    else if (exp_known) check("rd_data", 32'(rd_data), 32'(exp_data));
    check("swap_ack", 32'(swap_ack), 32'(exp_ack));
    check("front_bank", 32'(front_bank), 32'(front_m));
    check("busy", 32'(busy), 32'(exp_busy));
    check("wr_ready", 32'(wr_ready), 32'(!exp_busy));
  endtask

  task automatic model_read(input bit re, input int ra);
    exp_valid = re;
    if (re) begin
      exp_data  = mem_m[front_m][ra];
      exp_known = known[front_m][ra];
    end
  endtask

  // One cycle with the clear engine idle: read old front, write old back, then swap.
  task automatic idle_cyc(input bit we, input int wa, input logic [127:0] wd,
                          input bit re, input int ra, input bit sw, input bit cl);
    check_out(1'b0);
    drive(we, wa, wd, re, ra, sw, cl);
    model_read(re, ra);
    if (we) begin
      for (int k = 0; k < BP; k++) begin
        mem_m[~front_m][wa*BP+k] = wd[k*8 +: 8];
        known[~front_m][wa*BP+k] = 1'b1;
      end
    end
    exp_ack = sw;
    if (sw) front_m = ~front_m;
    tick();
  endtask

  task automatic rand_cyc();
    idle_cyc(rbit(2), int'($urandom_range(NB-1, 0)), rnd128(), rbit(2),
             int'($urandom_range(DEP-1, 0)), rbit(8), (!CLR) && rbit(6));
  endtask

  task automatic sweep();
    for (int a = 0; a < DEP; a++) idle_cyc(1'b0, 0, '0, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    int cnt;
    reset = 1'b0;
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0);
    repeat (n) tick();
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_swap_ack", 32'(swap_ack), 32'(0));
    check("rst_front", 32'(front_bank), 32'(0));
    check("rst_busy", 32'(busy), 32'(CLR));
    check("rst_wr_ready", 32'(wr_ready), 32'(!CLR));
    front_m   = 1'b0;
    exp_valid = 1'b0;
    exp_ack   = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEP; i++) begin
        mem_m[b][i] = 8'h00;
        known[b][i] = CLR;
      end
    reset = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      tick();
    end
    check("init_cycles", cnt, CLR ? 2*NB : 0);
  endtask

`ifndef IMG_FRAME_BUF_CLEAR_EN
  task automatic fill();
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < NB; b++)
        idle_cyc(1'b1, b, rnd128(), rbit(2), int'($urandom_range(DEP-1, 0)), 1'b0, rbit(4));
      idle_cyc(1'b0, 0, '0, 1'b0, 0, 1'b1, 1'b0);
    end
  endtask
`endif

`ifdef IMG_FRAME_BUF_CLEAR_EN
  task automatic clear_test(input bit with_swap, input int abort_at);
    int n;
    bit pend, re, sw;
    int ra;
    check_out(1'b0);
    re = rbit(2);
    ra = int'($urandom_range(DEP-1, 0));
    drive(1'b0, 0, '0, re, ra, with_swap, 1'b1);
    model_read(re, ra);
    exp_ack = 1'b0;
    pend = with_swap;
    tick();
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == abort_at) begin
        do_reset(1);
        return;
      end
      check_out(1'b1);
      re = rbit(2);
      ra = int'($urandom_range(DEP-1, 0));
      sw = rbit(16);
      // Writes and clear requests here must have no effect.
      drive(rbit(2), int'($urandom_range(NB-1, 0)), rnd128(), re, ra, sw, rbit(4));
      model_read(re, ra);
      exp_ack = 1'b0;
      pend |= sw;
      n++;
      tick();
    end
    check("clear_cycles", n, NB);
    for (int i = 0; i < DEP; i++) begin
      mem_m[~front_m][i] = 8'h00;
      known[~front_m][i] = 1'b1;
    end
    if (pend)
      idle_cyc(rbit(2), int'($urandom_range(NB-1, 0)), rnd128(), rbit(2),
               int'($urandom_range(DEP-1, 0)), 1'b1, 1'b0);
  endtask
`endif

  initial begin
    logic [127:0] d;
    reset = 1'b0;
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0);
    front_m = 1'b0; exp_valid = 1'b0; exp_ack = 1'b0; exp_known = 1'b0; exp_data = 8'h00;
    @(negedge clk);
    do_reset(3);
`ifndef IMG_FRAME_BUF_CLEAR_EN
    fill();
`endif
    sweep();
    idle_cyc(1'b0, 0, '0, 1'b0, 0, 1'b1, 1'b0);
    sweep();
    idle_cyc(1'b0, 0, '0, 1'b0, 0, 1'b1, 1'b0);

    // Beat 3 with byte k = 15-k, then swap and read pixels 48 and 63.
    for (int k = 0; k < BP; k++) d[k*8 +: 8] = 8'(15 - k);
    idle_cyc(1'b1, 3, d, 1'b0, 0, 1'b0, 1'b0);
    idle_cyc(1'b0, 0, '0, 1'b0, 0, 1'b1, 1'b0);
    idle_cyc(1'b0, 0, '0, 1'b1, 48, 1'b0, 1'b0);
    idle_cyc(1'b0, 0, '0, 1'b1, 63, 1'b0, 1'b0);
    idle_cyc(1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0);

    // Write + swap + read in one cycle: write lands in the new front, read sees the old one.
    idle_cyc(1'b1, 0, {16{8'hAA}}, 1'b1, 5, 1'b1, 1'b0);
    idle_cyc(1'b0, 0, '0, 1'b1, 0, 1'b0, 1'b0);
    idle_cyc(1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0);

    repeat (1500) rand_cyc();

`ifdef IMG_FRAME_BUF_CLEAR_EN
    clear_test(1'b1, -1);
    sweep();
    clear_test(1'b0, -1);
    repeat (300) rand_cyc();
    clear_test(1'b1, -1);
    clear_test(1'b0, 30);
    repeat (300) rand_cyc();
`else
    do_reset(2);
    fill();
    repeat (500) rand_cyc();
`endif

    idle_cyc(1'b0, 0, '0, 1'b0, 0, 1'b0, 1'b0);
    check_out(1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
